seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Multi-cycle integer divide/remainder unit. It is the inverse companion of the ALU's multiply path.
- Replaces the combinational `a / b` divide with a radix-2 restoring divider, one quotient bit per clock.
- Sits beside the ALU. The controller issues `start` and stalls on `busy` until `done`.
- Supports signed and unsigned operands with RISC-V DIV/DIVU/REM/REMU semantics.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  request; sampled only when idle or in DONE.
- is_signed  input  1  1 = two's-complement operands; 0 = unsigned. Sampled with start.
- a  input  WIDTH  dividend; sampled with start.
- b  input  WIDTH  divisor; sampled with start.
- busy  output  1  high from the cycle after start is accepted until done rises.
- done  output  1  one-cycle pulse; quotient/remainder valid this cycle and held afterwards.
- quotient  output  WIDTH  result quotient.
- remainder  output  WIDTH  result remainder.
- div_by_zero  output  1  registered flag for the last operation; valid from done.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - busy = 0, done = 0, quotient = 0, remainder = 0, div_by_zero = 0.
  - Internal shift/accumulator registers are cleared.
- States: IDLE, CALC, FIX, DONE.
- IDLE: start = 1 at a rising edge captures a, b, is_signed.
  - Normal case → CALC; the iteration counter loads WIDTH-1.
  - b == 0 → FIX directly (zero-divide bypass).
  - Signed overflow (is_signed, a = 100…0, b = all ones) → FIX directly (overflow bypass).
- Capture (signed): operands are converted to magnitudes. Stored flags:
  - neg_q = a[MSB] ^ b[MSB].
  - neg_r = a[MSB].
- Unsigned: operands are used as-is; both flags are 0.
- CALC, each cycle:
  - {rem, dvd} shifted left 1.
  - trial = rem_shifted − divisor, computed at WIDTH+1 bits.
  - trial non-negative → rem = trial, quotient bit = 1; otherwise the remainder is restored and the bit = 0.
  - Counter decrements; after the cycle in which the counter equals 0 → FIX. CALC lasts exactly WIDTH cycles.
- FIX: final results are registered.
  - Normal: quotient = neg_q ? −q : q; remainder = neg_r ? −r : r.
  - Zero-divide: quotient = all ones (both signednesses), remainder = a unmodified, div_by_zero = 1.
  - Overflow: quotient = a (100…0), remainder = 0, div_by_zero = 0.
  - Next state: DONE.
- DONE:
  - done = 1 for exactly this cycle.
  - busy = 0.
  - start = 1 here is accepted exactly as in IDLE (back-to-back); otherwise → IDLE.
- Latency, counted from the start-sampling edge to the edge where done rises:
  - Normal: WIDTH+2 cycles (34 for WIDTH = 32).
  - Bypass: 2 cycles.
- busy = 1 in CALC and FIX only.
- start while busy: ignored; no re-capture, no effect on the operation in flight.
- Outputs quotient/remainder/div_by_zero change only on the FIX→DONE edge and otherwise hold their last values, including through IDLE.
- Input changes on a/b/is_signed after acceptance have no effect.
- Reset asserted mid-operation aborts immediately to IDLE with all outputs cleared. No done pulse is produced for the aborted operation.
- Invariant for all non-bypass results: a == quotient·b + remainder at WIDTH bits, with |remainder| < |b|.

Test Plan:
- Unsigned 100/7 (is_signed = 0) → quotient = 14, remainder = 2, done exactly 34 cycles after the start edge, busy high for cycles 1–33.
- Signed −7/2 (a = 0xFFFFFFF9, b = 2) → quotient = 0xFFFFFFFD (−3), remainder = 0xFFFFFFFF (−1). Also signed 7/−2 → quotient = 0xFFFFFFFD, remainder = 1.
- Divide by zero, a = 5, b = 0, both signednesses → quotient = 0xFFFFFFFF, remainder = 5, div_by_zero = 1, done 2 cycles after start.
- Signed overflow, a = 0x80000000, b = 0xFFFFFFFF → quotient = 0x80000000, remainder = 0, done at 2 cycles. The same operands unsigned → quotient = 0, remainder = 0x80000000 at 34 cycles.
- Control corner cases:
  - start pulsed at cycle 10 of an operation → ignored, original result intact.
  - start held through DONE → second op (0xFFFFFFFF/1 unsigned → quotient = 0xFFFFFFFF, remainder = 0) begins back-to-back.
  - reset driven low at cycle 20 → busy = 0, quotient = remainder = 0 immediately, no done pulse.
- Random regression, 10k operand pairs in both modes → every result matches a reference model, and the invariant a == q·b + r holds.

Source files
------------

// File: rtl/seq_divider.sv
// Radix-2 restoring integer divider, one quotient bit per clock.
// RISC-V DIV/DIVU/REM/REMU semantics including zero-divide and signed-overflow bypasses.
module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] a_raw;
  logic [CW-1:0]    cnt;
  logic             neg_q;
  logic             neg_r;
  logic             zero_div;
  logic             ovf;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             ovf_in;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] dvd_next;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // Operand conditioning at capture plus one restoring-division step
  always_comb begin
    a_neg    = is_signed & a[WIDTH-1];
    b_neg    = is_signed & b[WIDTH-1];
    a_mag    = a_neg ? (~a + 1'b1) : a;
    b_mag    = b_neg ? (~b + 1'b1) : b;
    ovf_in   = is_signed && (a == MIN_NEG) && (b == '1);
    shifted  = {rem, dvd[WIDTH-1]};
    trial    = shifted - {1'b0, dsr};
    rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    dvd_next = {dvd[WIDTH-2:0], ~trial[WIDTH]};
    q_fix    = neg_q ? (~dvd + 1'b1) : dvd;
    r_fix    = neg_r ? (~rem + 1'b1) : rem;
  end

  // Control FSM, datapath registers and registered outputs.
  // busy/done are registered from the previous state, so each trails the
  // state by one cycle: done pulses on the cycle after DONE is entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      dvd         <= '0;
      rem         <= '0;
      dsr         <= '0;
      a_raw       <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      zero_div    <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      busy <= (state == CALC) || (state == FIX);
      done <= (state == DONE);
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_raw    <= a;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            dvd      <= a_mag;
            dsr      <= b_mag;
            rem      <= '0;
            cnt      <= CNT_LOAD;
            zero_div <= (b == '0);
            ovf      <= ovf_in;
            state    <= ((b == '0) || ovf_in) ? FIX : CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          dvd <= dvd_next;
          rem <= rem_next;
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          if (zero_div) begin
            quotient    <= '1;
            remainder   <= a_raw;
            div_by_zero <= 1'b1;
          end else if (ovf) begin
            quotient    <= a_raw;
            remainder   <= '0;
            div_by_zero <= 1'b0;
          end else begin
            quotient    <= q_fix;
            remainder   <= r_fix;
            div_by_zero <= 1'b0;
          end
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH = 32).
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .is_signed(is_signed),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge; the next edge is the start-sampling edge.
  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic s);
    a = x; b = y; is_signed = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom; is_signed = ~s;
  endtask

  // Counts edges after the start edge until done; busy must be high before done and low at done.
  task automatic wait_done(input int glitch_at, output int lat, output int busy_bad);
    lat = 0;
    busy_bad = 0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        if (busy) busy_bad++;
        break;
      end
      if (!busy) busy_bad++;
      if (glitch_at != 0) begin
        start = (n == glitch_at);
        if (n == glitch_at) begin a = 32'd55; b = 32'd3; end
      end
    end
  endtask

  task automatic run_vec(input string tag, input logic [31:0] x, input logic [31:0] y, input logic s,
                         input logic [31:0] eq, input logic [31:0] er, input logic edz,
                         input int elat, input int glitch_at);
    int lat, bb;
    issue(x, y, s);
    wait_done(glitch_at, lat, bb);
    check({tag, "_lat"}, lat, elat);
    check({tag, "_busy"}, bb, 0);
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_dz"}, {31'd0, div_by_zero}, {31'd0, edz});
    @(posedge clk); #1;
    check({tag, "_pulse"}, {31'd0, done}, 32'd0);
  endtask

  // Independent RISC-V divide reference
  task automatic ref_div(input logic [31:0] x, input logic [31:0] y, input logic s,
                         output logic [31:0] q, output logic [31:0] r, output logic dz);
    logic signed [31:0] sx, sy;
    sx = x; sy = y;
    dz = (y == 32'd0);
    if (y == 32'd0) begin
      q = 32'hFFFF_FFFF; r = x;
    end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      q = x; r = 32'd0;
    end else if (s) begin
      q = sx / sy; r = sx % sy;
    end else begin
      q = x / y; r = x % y;
    end
  endtask

  initial begin
    int lat, bb, seen;
    logic [31:0] rx, ry, eq, er, prod;
    logic rs, edz;

    // Reset state
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    check("rst_dz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Directed vectors
    run_vec("u100_7",   32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 34, 0);
    run_vec("s-7_2",    32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 34, 0);
    run_vec("s7_-2",    32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0, 34, 0);
    run_vec("s-100_-7", 32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, 32'd14,         32'hFFFF_FFFE,  1'b0, 34, 0);
    run_vec("u5_0",     32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,          1'b1, 2,  0);
    run_vec("s5_0",     32'd5,          32'd0,          1'b1, 32'hFFFF_FFFF,  32'd5,          1'b1, 2,  0);
    run_vec("s_ovf",    32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0, 2,  0);
    run_vec("u_ovfops", 32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  1'b0, 34, 0);
    run_vec("u_max_16", 32'hFFFF_FFFF,  32'h10,         1'b0, 32'h0FFF_FFFF,  32'hF,          1'b0, 34, 0);
    run_vec("s0_5",     32'd0,          32'd5,          1'b1, 32'd0,          32'd0,          1'b0, 34, 0);

    // start pulsed mid-operation is ignored
    run_vec("glitch",   32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 34, 10);

    // start held through DONE launches the next operation back-to-back
    a = 32'd100; b = 32'd7; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 32'hFFFF_FFFF; b = 32'd1;
    wait_done(0, lat, bb);
    check("b2b1_lat", lat, 34);
    check("b2b1_q", quotient, 32'd14);
    check("b2b1_r", remainder, 32'd2);
    start = 1'b0;
    a = $urandom; b = $urandom;
    wait_done(0, lat, bb);
    check("b2b2_lat", lat, 34);
    check("b2b2_busy", bb, 0);
    check("b2b2_q", quotient, 32'hFFFF_FFFF);
    check("b2b2_r", remainder, 32'd0);
    @(posedge clk); #1;

    // Reset mid-operation aborts with outputs cleared and no done pulse
    issue(32'd1000, 32'd3, 1'b0);
    for (int n = 1; n < 20; n++) begin @(posedge clk); #1; end
    reset = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_q", quotient, 32'd0);
    check("abort_r", remainder, 32'd0);
    seen = 0;
    repeat (2) begin @(posedge clk); #1; if (done || busy) seen++; end
    @(negedge clk); reset = 1'b1;
    repeat (40) begin @(posedge clk); #1; if (done || busy) seen++; end
    check("abort_nodone", seen, 0);

    // Short pseudo-random batch against the reference model
    for (int i = 0; i < 40; i++) begin
      rx = $urandom;
      ry = $urandom >> $urandom_range(0, 31);
      if (i % 10 == 3) ry = 32'd0;
      rs = i[0];
      ref_div(rx, ry, rs, eq, er, edz);
      issue(rx, ry, rs);
      wait_done(0, lat, bb);
      check("rnd_q", quotient, eq);
      check("rnd_r", remainder, er);
      check("rnd_dz", {31'd0, div_by_zero}, {31'd0, edz});
      if (!edz) begin
        prod = quotient * ry + remainder;
        check("rnd_inv", prod, rx);
      end
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
